// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings and helpers for the data-memory arbiter (CPU port vs. debug/loader port).
// The owner output reuses the FSM state encoding directly.
package dmem_arbiter_pkg;

  localparam int ADDR_W_DEF = 64;
  localparam int DATA_W_DEF = 64;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CPU  = 2'd1;
  localparam logic [1:0] ST_DBG  = 2'd2;
  localparam logic [1:0] ST_LOCK = 2'd3;

  function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
    return (v >= lim) ? lim : v + 4'd1;
  endfunction

endpackage

// File: rtl/arb_fair_cnt.sv
// Saturating count of cycles a pending debug request has been refused; raises dbg_force
// once the refusal count reaches FAIR_LIMIT so debug cannot be starved by the CPU.
module arb_fair_cnt
  import dmem_arbiter_pkg::*;
#(
  parameter int FAIR_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic dbg_req,
  input  logic dbg_gnt,
  output logic dbg_force
);

  localparam logic [3:0] LIMIT = 4'(FAIR_LIMIT);

  logic [3:0] wait_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (dbg_req && !dbg_gnt) begin
      wait_cnt <= sat_inc(wait_cnt, LIMIT);
    end else begin
      wait_cnt <= '0;
    end
  end

  assign dbg_force = dbg_req & (wait_cnt == LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: CPU has default priority, debug is served after a bounded
// wait or owns the memory while locked. Optional performance counters under ARB_PERF_EN.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FAIR_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_lock,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  input  logic              halt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner
`ifdef ARB_PERF_EN
  ,
  output logic [31:0]       cpu_acc_cnt,
  output logic [31:0]       dbg_acc_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       cpu_gnt;
  logic       dbg_gnt;
  logic       dbg_force;

  arb_fair_cnt #(
    .FAIR_LIMIT(FAIR_LIMIT)
  ) u_fair_cnt (
    .clk      (clk),
    .rst      (rst),
    .dbg_req  (dbg_req),
    .dbg_gnt  (dbg_gnt),
    .dbg_force(dbg_force)
  );

  // Qualifying grants with rst keeps every output at 0 while reset is held, which also
  // suppresses mem_we so an in-flight write is aborted at the next edge.
  assign cpu_gnt = rst & cpu_req & ~halt & (state != ST_LOCK) & ~dbg_force;
  assign dbg_gnt = rst & dbg_req & ((state == ST_LOCK) | halt | ~cpu_req | dbg_force);

  assign cpu_stall = rst & cpu_req & ~halt & ~cpu_gnt;
  assign dbg_ack   = dbg_gnt;
  assign cpu_rdata = cpu_gnt ? mem_rdata : '0;
  assign dbg_rdata = dbg_gnt ? mem_rdata : '0;
  assign owner     = state;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dbg_gnt) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  always_comb begin
    state_nxt = ST_IDLE;
    if ((dbg_gnt && dbg_lock) || (state == ST_LOCK && dbg_lock)) begin
      state_nxt = ST_LOCK;
    end else if (cpu_gnt) begin
      state_nxt = ST_CPU;
    end else if (dbg_gnt) begin
      state_nxt = ST_DBG;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

`ifdef ARB_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_acc_cnt <= '0;
      dbg_acc_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (cpu_gnt)   cpu_acc_cnt <= cpu_acc_cnt + 32'd1;
      if (dbg_gnt)   dbg_acc_cnt <= dbg_acc_cnt + 32'd1;
      if (cpu_stall) stall_cnt   <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the CPU load/store port (MEM stage) and a debug/loader port that preloads data or reads results back after halt.
- Sits between top and Data_Mem.
- CPU has default priority, and debug waits a bounded number of cycles.
- A debug lock mode gives debug exclusive ownership of the memory for bursts.

Parameters:
ADDR_W, 64, address width of all ports
DATA_W, 64, data word width
FAIR_LIMIT, 4, maximum consecutive cycles a pending debug request may be refused (1..15)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
cpu_req  in  1  CPU access request, valid for the current cycle
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU byte address
cpu_wdata  in  DATA_W  CPU store data
cpu_rdata  out  DATA_W  load data; 0 when the CPU is not granted
cpu_stall  out  1  cpu_req and not granted this cycle; pipeline must hold MEM stage
dbg_req  in  1  debug access request, held until dbg_ack
dbg_we  in  1  1 = write
dbg_addr  in  ADDR_W  debug byte address
dbg_wdata  in  DATA_W  debug write data
dbg_lock  in  1  request exclusive ownership for a burst
dbg_rdata  out  DATA_W  read data, valid in the dbg_ack cycle; otherwise 0
dbg_ack  out  1  debug access performed this cycle
halt  in  1  CPU halted; CPU requests are ignored
mem_we  out  1  write enable to memory; write commits on the clk rising edge
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  combinational read data from memory
owner  out  2  0 = none, 1 = CPU, 2 = debug, 3 = debug locked

Behaviour:
- One memory access per cycle. Grant is combinational from the registered state plus the current requests.
- Read data returns in the same cycle. A write commits at the next rising edge.
- Registered state: FSM {IDLE, CPU, DBG, LOCK}, and wait_cnt (4 bits).
- Grant rules:
  - cpu_gnt = cpu_req & ~halt & state!=LOCK & ~dbg_force.
  - dbg_force = dbg_req & (wait_cnt==FAIR_LIMIT).
  - dbg_gnt = dbg_req & (state==LOCK | halt | ~cpu_req | dbg_force).
  - cpu_gnt and dbg_gnt are mutually exclusive by construction.
- Memory mux:
  - The granted port drives mem_addr, mem_wdata and mem_we.
  - With no grant, mem_we=0 and mem_addr/mem_wdata = 0.
- Read data routing: cpu_rdata = cpu_gnt ? mem_rdata : 0. dbg_rdata = dbg_gnt ? mem_rdata : 0.
- dbg_ack = dbg_gnt. cpu_stall = cpu_req & ~halt & ~cpu_gnt.
- When halt=1, cpu_stall=0 and CPU requests are dropped.
- wait_cnt:
  - Increments each cycle dbg_req=1 and dbg_gnt=0, saturating at FAIR_LIMIT.
  - Clears on dbg_gnt or dbg_req=0.
- FSM next state:
  - LOCK when dbg_gnt & dbg_lock.
  - Stays in LOCK while dbg_lock=1; leaves LOCK when dbg_lock=0.
  - Otherwise: CPU if cpu_gnt, DBG if dbg_gnt, else IDLE.
- In LOCK the CPU is stalled every cycle cpu_req=1, including when dbg_req=0.
- owner reflects the registered state.
- Reset (rst=0, asynchronous): state=IDLE and wait_cnt=0.
  - While rst=0, all outputs are forced to 0, including mem_we, cpu_stall and dbg_ack.
  - Reset mid-write therefore aborts the write; no memory update at the edge.
- Simultaneous cpu_req & dbg_req with wait_cnt<FAIR_LIMIT: CPU wins.
- At wait_cnt==FAIR_LIMIT: debug wins exactly one cycle, then the counter clears.
- dbg_lock asserted without dbg_req: no effect until a debug grant occurs.

Optional Feature:
- Macro ARB_PERF_EN.
- When defined, adds outputs cpu_acc_cnt[31:0], dbg_acc_cnt[31:0] and stall_cnt[31:0]:
  - cpu_acc_cnt increments on cpu_gnt; dbg_acc_cnt increments on dbg_gnt; stall_cnt increments on cpu_stall.
  - The counters wrap at 2^32 and clear on reset.
- When undefined, these ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/header holds:
  - FSM state encodings ST_IDLE=0, ST_CPU=1, ST_DBG=2, ST_LOCK=3 (owner uses the same encoding).
  - Default widths ADDR_W/DATA_W=64.
- Sub-module arb_fair_cnt: the saturating wait counter and dbg_force compare, parameterised by FAIR_LIMIT.
- The mux and FSM stay in dmem_arbiter.

Test Plan:
- Reset hold:
  - Stimulus: rst=0 with cpu_req=1, cpu_we=1.
  - Response: mem_we=0, cpu_stall=0, owner=0. DM[0..15] are unchanged after 3 edges.
- CPU only:
  - Stimulus: write 0x1234 to address 8, then read address 8.
  - Response: no stall. cpu_rdata=0x1234 in the read cycle. owner=1.
- Fairness with FAIR_LIMIT=4:
  - Stimulus: cpu_req held at 1, and dbg_req read of address 16 asserted at cycle 0.
  - Response: cpu_stall=0 on cycles 0-3. Cycle 4: dbg_ack=1 and cpu_stall=1. Cycle 5: CPU granted again.
- Lock burst:
  - Stimulus: dbg_lock=1 with debug writes to addresses 8, 16, 24 (values 1, 2, 3), while cpu_req=1. Then lock is released.
  - Response: cpu_stall=1 for the whole burst plus the lock-hold cycles. owner=3. Words 1, 2 and 3 read back as 1, 2, 3.
- Halt readback:
  - Stimulus: halt=1 with cpu_req=1, and a debug read of address 8.
  - Response: dbg_ack in the same cycle, cpu_stall=0, and the CPU address is not driven to memory.
- Async reset mid-lock:
  - Stimulus: rst pulsed low between edges while owner=3.
  - Response: outputs go to 0 immediately. After release, owner=0 and the next cpu_req is granted at once.
